pwm_cfg_ctrl: RTL and testbench
===============================

PWM_CFG_CTRL -- requirements
Module: pwm_cfg_ctrl

Interface
REQ-001 Parameters: none; all widths fixed at 16 bits to match the triangle-wave datapath.
REQ-002 Reset RstN, synchronous, active-low; clock MClk.
REQ-003 MClk  in  1  master clock; all state updates on rising edge.
REQ-004 RstN  in  1  synchronous active-low reset.
REQ-005 CfgValid  in  1  config write request.
REQ-006 CfgReady  out  1  controller can accept a config this cycle.
REQ-007 CfgUpper / CfgLower / CfgStep  in  16 each  requested UpperLimit / LowerLimit / StepSize.
REQ-008 CfgErr  out  1  one-cycle pulse: accepted config was invalid and was discarded.
REQ-009 StartReq / StopReq  in  1 each  run-control requests, level-sampled each cycle.
REQ-010 TWave  in  16  triangle-wave generator output, fed back.
REQ-011 TwgEn  out  1  generator enable.
REQ-012 TwgUpper / TwgLower / TwgStep  out  16 each  active limits and step to the generator.
REQ-013 ValleyTick  out  1  one-cycle pulse at each detected wave minimum while running.
REQ-014 Running  out  1  high in RUN and DRAIN.
REQ-015 PeriodCnt  out  16  count of ValleyTicks since last start; wraps 0xFFFF->0.

Function
REQ-016 States: IDLE, RUN, DRAIN; 2-bit encoding, any unused code returns to IDLE next cycle.
REQ-017 A handshake completes on a cycle with CfgValid=1 and CfgReady=1; CfgUpper/CfgLower/CfgStep are sampled that cycle.
REQ-018 CfgReady=1 iff no shadow config is pending.
REQ-019 A config is valid iff CfgLower < CfgUpper, CfgStep != 0, and CfgStep <= CfgUpper-CfgLower (17-bit compare, no wrap).
REQ-020 An invalid config completes the handshake, pulses CfgErr the next cycle, and leaves shadow and active registers unchanged.
REQ-021 A valid config accepted in IDLE loads the active registers the next cycle, sets Loaded=1, and leaves pending at 0.
REQ-022 A valid config accepted in RUN or DRAIN loads the shadow registers and sets pending=1.
REQ-023 A pending shadow is copied to the active registers on the edge that ends a ValleyTick cycle, or on entry to IDLE; pending then clears.
REQ-024 Valley detection keeps TWavePrev and a Falling flag (TWave < TWavePrev, sampled each cycle).
REQ-025 ValleyTick=1 in a cycle when the previous cycle had Falling=1 and TWave > TWavePrev; ValleyTick is gated to 0 in IDLE.
REQ-026 IDLE -> RUN on StartReq=1 and StopReq=0 with Loaded=1; TwgEn rises on the same edge; PeriodCnt and Falling clear.
REQ-027 StartReq with Loaded=0 is ignored.
REQ-028 RUN -> DRAIN on StopReq=1; StartReq in RUN or DRAIN is ignored.
REQ-029 DRAIN -> IDLE on the edge ending a ValleyTick cycle; TwgEn falls on that same edge.
REQ-030 PeriodCnt increments on each ValleyTick in RUN or DRAIN.
REQ-031 When StartReq and StopReq are both high in IDLE, Stop wins and the state remains IDLE.
REQ-032 TwgUpper/TwgLower/TwgStep always equal the active registers; they never change mid-period while TwgEn=1.

Reset
REQ-033 RstN=0 on any edge, including mid-RUN or with pending=1, forces: state=IDLE, TwgEn=0, Loaded=0, pending=0, CfgReady=1, CfgErr=0, ValleyTick=0, Running=0, PeriodCnt=0, TWavePrev=0, Falling=0.
REQ-034 The same reset sets active and shadow registers to Upper=0xFFFF, Lower=0x0000, Step=0x0001.

Verification
REQ-035 Load config (1000,0,100) in IDLE, then StartReq -> TwgEn=1 and TwgUpper=1000 after 1 cycle; first ValleyTick after one full generator period; PeriodCnt=1.
REQ-036 In RUN, write (2000,500,250) -> CfgReady=0 until the next ValleyTick; limits change only on the edge ending that tick; CfgReady=1 after.
REQ-037 Write (100,100,1) and, separately, (100,0,0) -> CfgErr pulses once each; active registers unchanged.
REQ-038 StopReq mid-rise in RUN -> Running stays 1 through DRAIN; TwgEn=0 and state=IDLE on the edge ending the next ValleyTick.
REQ-039 StartReq and StopReq together in IDLE -> stays IDLE; StartReq with Loaded=0 -> stays IDLE.
REQ-040 RstN=0 in RUN with pending=1 -> all REQ-033/034 values on the next edge; the pending config is lost.

Source files
------------

// File: rtl/pwm_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_cfg_ctrl_if
//   Configuration write channel of the PWM triangle-wave controller.
//   A request (CfgValid) carries a candidate UpperLimit / LowerLimit / StepSize
//   triple. The transfer completes on a cycle where CfgValid and CfgReady are
//   both high. CfgErr reports, one cycle later, that the accepted triple was
//   rejected.
//
//   Signals
//     CfgValid  master->slave  config write request
//     CfgReady  slave->master  controller can take a config this cycle
//     CfgUpper  master->slave  requested UpperLimit (16 bit)
//     CfgLower  master->slave  requested LowerLimit (16 bit)
//     CfgStep   master->slave  requested StepSize   (16 bit)
//     CfgErr    slave->master  one-cycle pulse: last accepted config discarded
// ---------------------------------------------------------------------------
interface pwm_cfg_ctrl_if;
  logic        CfgValid;
  logic        CfgReady;
  logic [15:0] CfgUpper;
  logic [15:0] CfgLower;
  logic [15:0] CfgStep;
  logic        CfgErr;

  modport master (
    output CfgValid,
    output CfgUpper,
    output CfgLower,
    output CfgStep,
    input  CfgReady,
    input  CfgErr
  );

  modport slave (
    input  CfgValid,
    input  CfgUpper,
    input  CfgLower,
    input  CfgStep,
    output CfgReady,
    output CfgErr
  );
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_cfg_ctrl
//   Run-control and configuration manager for a 16-bit triangle-wave PWM
//   generator. It validates incoming limit/step configurations, applies them
//   immediately while idle, and otherwise holds them in a shadow set that is
//   only copied to the generator at a wave minimum, so the generator never
//   sees a limit change in the middle of a period. It also detects the wave
//   minima from the fed-back waveform, counts periods, and sequences
//   IDLE -> RUN -> DRAIN -> IDLE, where DRAIN lets the current period finish
//   before the generator is disabled.
//
//   Ports
//     MClk        in   master clock, rising edge
//     RstN        in   synchronous active-low reset
//     cfg         slave modport of pwm_cfg_ctrl_if (config write channel)
//     StartReq    in   start request, level-sampled
//     StopReq     in   stop request, level-sampled (wins over StartReq)
//     TWave       in   generator output, fed back for valley detection
//     TwgEn       out  generator enable
//     TwgUpper    out  active UpperLimit
//     TwgLower    out  active LowerLimit
//     TwgStep     out  active StepSize
//     ValleyTick  out  one-cycle pulse at each wave minimum while running
//     Running     out  high in RUN and DRAIN
//     PeriodCnt   out  valley count since the last start, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module pwm_cfg_ctrl (
  input  logic                 MClk,
  input  logic                 RstN,
  pwm_cfg_ctrl_if.slave        cfg,
  input  logic                 StartReq,
  input  logic                 StopReq,
  input  logic [15:0]          TWave,
  output logic                 TwgEn,
  output logic [15:0]          TwgUpper,
  output logic [15:0]          TwgLower,
  output logic [15:0]          TwgStep,
  output logic                 ValleyTick,
  output logic                 Running,
  output logic [15:0]          PeriodCnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  typedef struct packed {
    logic [15:0] upper;
    logic [15:0] lower;
    logic [15:0] step;
  } lim_t;

  // Power-on limits: full 16-bit swing with unit step.
  localparam lim_t LIM_RST = {16'hFFFF, 16'h0000, 16'h0001};

  // A triple is usable when the window is non-empty and one step fits inside
  // it. The span is formed in 17 bits so the subtraction can never wrap.
  function automatic logic cfg_is_valid(input lim_t c);
    logic [16:0] span;
    span = {1'b0, c.upper} - {1'b0, c.lower};
    return (c.lower < c.upper) && (c.step != 16'd0) && ({1'b0, c.step} <= span);
  endfunction

  state_e      state_q,  state_d;
  logic        en_q,     en_d;
  logic        loaded_q, loaded_d;
  logic        pend_q,   pend_d;
  logic        err_q,    err_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [15:0] prev_q,   prev_d;
  logic        fall_q,   fall_d;
  lim_t        act_q,    act_d;
  lim_t        shd_q,    shd_d;

  lim_t        cfg_in;
  logic        cfg_good;
  logic        hs;
  logic        active_run;
  logic        in_idle;
  logic        vtick;
  logic        start_go;

  assign cfg_in     = {cfg.CfgUpper, cfg.CfgLower, cfg.CfgStep};
  assign cfg_good   = cfg_is_valid(cfg_in);
  // Only one config can be outstanding; the channel stalls while a shadow
  // set waits for its valley.
  assign hs         = cfg.CfgValid && !pend_q;
  assign in_idle    = (state_q == ST_IDLE);
  assign active_run = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // A minimum is seen one cycle late: the wave was falling into the previous
  // sample and is now above it.
  assign vtick      = active_run && fall_q && (TWave > prev_q);
  assign start_go   = in_idle && StartReq && !StopReq && loaded_q;

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    loaded_d = loaded_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    shd_d    = shd_q;
    prev_d   = TWave;
    fall_d   = (TWave < prev_q);
    err_d    = hs && !cfg_good;

    // Shadow promotion: at a valley, or whenever the controller is not
    // running. The latter also covers a shadow written on the very edge that
    // drained into IDLE, which is then promoted one cycle later.
    if (pend_q && (vtick || !active_run)) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    // Promotion and acceptance are mutually exclusive: hs needs pend_q = 0.
    if (hs && cfg_good) begin
      if (in_idle) begin
        act_d    = cfg_in;
        loaded_d = 1'b1;
      end else begin
        shd_d  = cfg_in;
        pend_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
          cnt_d   = 16'd0;
          fall_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (vtick) cnt_d = cnt_q + 16'd1;
        if (StopReq) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vtick) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MClk) begin
    if (!RstN) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      loaded_q <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
      prev_q   <= 16'd0;
      fall_q   <= 1'b0;
      act_q    <= LIM_RST;
      shd_q    <= LIM_RST;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      loaded_q <= loaded_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      fall_q   <= fall_d;
      act_q    <= act_d;
      shd_q    <= shd_d;
    end
  end

  assign cfg.CfgReady = !pend_q;
  assign cfg.CfgErr   = err_q;
  assign TwgEn        = en_q;
  assign TwgUpper     = act_q.upper;
  assign TwgLower     = act_q.lower;
  assign TwgStep      = act_q.step;
  assign ValleyTick   = vtick;
  assign Running      = active_run;
  assign PeriodCnt    = cnt_q;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
module tb_pwm_cfg_ctrl;

  logic        MClk = 1'b0;
  logic        RstN = 1'b0;
  logic        StartReq = 1'b0;
  logic        StopReq = 1'b0;
  logic [15:0] TWave = 16'd0;
  logic        TwgEn;
  logic [15:0] TwgUpper, TwgLower, TwgStep;
  logic        ValleyTick, Running;
  logic [15:0] PeriodCnt;

  pwm_cfg_ctrl_if cfg();

  pwm_cfg_ctrl dut (
    .MClk       (MClk),
    .RstN       (RstN),
    .cfg        (cfg),
    .StartReq   (StartReq),
    .StopReq    (StopReq),
    .TWave      (TWave),
    .TwgEn      (TwgEn),
    .TwgUpper   (TwgUpper),
    .TwgLower   (TwgLower),
    .TwgStep    (TwgStep),
    .ValleyTick (ValleyTick),
    .Running    (Running),
    .PeriodCnt  (PeriodCnt)
  );

  always #5 MClk = ~MClk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural triangle generator driven by the DUT's enable and limits.
  int wv = 0;
  bit wup = 1'b1;
  bit use_gen = 1'b1;

  task automatic gen_step();
    if (use_gen) begin
      if (!TwgEn) begin
        wv  = int'(TwgLower);
        wup = 1'b1;
      end else if (wup) begin
        if (wv + int'(TwgStep) >= int'(TwgUpper)) begin wv = int'(TwgUpper); wup = 1'b0; end
        else wv = wv + int'(TwgStep);
      end else begin
        if (wv <= int'(TwgLower) + int'(TwgStep)) begin wv = int'(TwgLower); wup = 1'b1; end
        else wv = wv - int'(TwgStep);
      end
      TWave = 16'(wv);
    end
  endtask

  // One clock: inputs set beforehand are captured on the rising edge; outputs
  // are then inspected just after the falling edge.
  task automatic tick_clk();
    @(posedge MClk);
    @(negedge MClk);
    gen_step();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_TwgEn"},    32'(TwgEn), 32'd0);
    chk({tag, "_Running"},  32'(Running), 32'd0);
    chk({tag, "_CfgReady"}, 32'(cfg.CfgReady), 32'd1);
    chk({tag, "_CfgErr"},   32'(cfg.CfgErr), 32'd0);
    chk({tag, "_Valley"},   32'(ValleyTick), 32'd0);
    chk({tag, "_PeriodCnt"},32'(PeriodCnt), 32'd0);
    chk({tag, "_Upper"},    32'(TwgUpper), 32'hFFFF);
    chk({tag, "_Lower"},    32'(TwgLower), 32'h0000);
    chk({tag, "_Step"},     32'(TwgStep), 32'h0001);
  endtask

  // ---------------- reference model (used in the randomized phase) --------
  typedef struct packed { logic [15:0] u; logic [15:0] l; logic [15:0] s; } lims_t;

  bit          m_run, m_drain, m_loaded, m_pend, m_err;
  logic [15:0] m_cnt;
  lims_t       m_act, m_shd;
  logic [15:0] m_hist[$];   // last two wave samples, oldest first

  function automatic bit cfg_legal(input int u, input int l, input int s);
    return (l < u) && (s != 0) && (s <= u - l);
  endfunction

  function automatic bit m_tick(input logic [15:0] tw);
    if (!m_run || m_hist.size() != 2) return 1'b0;
    return (m_hist[0] > m_hist[1]) && (tw > m_hist[1]);
  endfunction

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_loaded = 0; m_pend = 0; m_err = 0;
    m_cnt = 16'd0;
    m_act = '{16'hFFFF, 16'h0000, 16'h0001};
    m_shd = '{16'hFFFF, 16'h0000, 16'h0001};
    m_hist.delete();
  endtask

  task automatic model_update(input bit rst_n, input bit vld, input lims_t c,
                              input bit start, input bit stop, input logic [15:0] tw);
    bit tick, hs, good, was_loaded;
    if (!rst_n) begin model_reset(); return; end
    tick = m_tick(tw);
    hs   = vld && !m_pend;
    good = cfg_legal(int'(c.u), int'(c.l), int'(c.s));
    was_loaded = m_loaded;
    m_err = hs && !good;
    if (m_pend && (tick || !m_run)) begin m_act = m_shd; m_pend = 0; end
    if (hs && good) begin
      if (!m_run) begin m_act = c; m_loaded = 1; end
      else begin m_shd = c; m_pend = 1; end
    end
    if (!m_run && start && !stop && was_loaded) begin
      m_run = 1; m_drain = 0; m_cnt = 16'd0;
      m_hist.delete();
      m_hist.push_back(tw);
    end else begin
      if (m_run) begin
        if (tick) m_cnt = m_cnt + 16'd1;
        if (m_drain && tick) begin m_run = 0; m_drain = 0; end
        else if (!m_drain && stop) m_drain = 1;
      end
      m_hist.push_back(tw);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
    end
  endtask

  // ---------------- config validity table --------------------------------
  typedef struct {
    logic [15:0] up, lo, st;
    logic        err;
    logic [15:0] eu, el, es;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit hold_bad;
    lims_t rc;

    tbl[0] = '{16'd100,   16'd100,   16'd1,     1'b1, 16'hFFFF, 16'h0000, 16'h0001};
    tbl[1] = '{16'd100,   16'd0,     16'd0,     1'b1, 16'hFFFF, 16'h0000, 16'h0001};
    tbl[2] = '{16'd1000,  16'd0,     16'd100,   1'b0, 16'd1000, 16'd0,    16'd100};
    tbl[3] = '{16'd50,    16'd100,   16'd1,     1'b1, 16'd1000, 16'd0,    16'd100};
    tbl[4] = '{16'd100,   16'd0,     16'd101,   1'b1, 16'd1000, 16'd0,    16'd100};
    tbl[5] = '{16'd100,   16'd0,     16'd100,   1'b0, 16'd100,  16'd0,    16'd100};
    tbl[6] = '{16'hFFFF,  16'hFFFE,  16'd2,     1'b1, 16'd100,  16'd0,    16'd100};
    tbl[7] = '{16'hFFFF,  16'h0000,  16'hFFFF,  1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[8] = '{16'd1,     16'd0,     16'd1,     1'b0, 16'd1,    16'd0,    16'd1};
    tbl[9] = '{16'd1000,  16'd0,     16'd100,   1'b0, 16'd1000, 16'd0,    16'd100};

    cfg.CfgValid = 1'b0;
    cfg.CfgUpper = 16'd0;
    cfg.CfgLower = 16'd0;
    cfg.CfgStep  = 16'd0;

    // Reset
    RstN = 1'b0;
    tick_clk();
    tick_clk();
    check_reset_vals("rst");
    RstN = 1'b1;

    // Start with nothing loaded is ignored
    StartReq = 1'b1;
    tick_clk();
    StartReq = 1'b0;
    chk("start_unloaded_running", 32'(Running), 32'd0);
    chk("start_unloaded_en",      32'(TwgEn),   32'd0);

    // Config validity table (all applied in IDLE)
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_ready", i), 32'(cfg.CfgReady), 32'd1);
      cfg.CfgValid = 1'b1;
      cfg.CfgUpper = tbl[i].up;
      cfg.CfgLower = tbl[i].lo;
      cfg.CfgStep  = tbl[i].st;
      tick_clk();
      cfg.CfgValid = 1'b0;
      chk($sformatf("tbl%0d_err", i),   32'(cfg.CfgErr), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_upper", i), 32'(TwgUpper),   32'(tbl[i].eu));
      chk($sformatf("tbl%0d_lower", i), 32'(TwgLower),   32'(tbl[i].el));
      chk($sformatf("tbl%0d_step", i),  32'(TwgStep),    32'(tbl[i].es));
      tick_clk();
      chk($sformatf("tbl%0d_err_end", i), 32'(cfg.CfgErr), 32'd0);
    end

    // Start with (1000,0,100): one full period of 20 steps to the first valley
    StartReq = 1'b1;
    tick_clk();
    StartReq = 1'b0;
    chk("run_en",      32'(TwgEn),    32'd1);
    chk("run_upper",   32'(TwgUpper), 32'd1000);
    chk("run_running", 32'(Running),  32'd1);
    chk("run_cnt0",    32'(PeriodCnt),32'd0);
    n = 1;
    while (!ValleyTick && n < 200) begin tick_clk(); n++; end
    chk("valley1_seen",  32'(ValleyTick), 32'd1);
    chk("valley1_cycle", 32'(n), 32'd21);
    tick_clk();
    chk("valley1_cnt", 32'(PeriodCnt), 32'd1);
    chk("valley1_pulse_end", 32'(ValleyTick), 32'd0);

    // Reconfigure while running: held in shadow until the next valley
    chk("shadow_ready_before", 32'(cfg.CfgReady), 32'd1);
    cfg.CfgValid = 1'b1;
    cfg.CfgUpper = 16'd2000;
    cfg.CfgLower = 16'd500;
    cfg.CfgStep  = 16'd250;
    tick_clk();
    cfg.CfgValid = 1'b0;
    chk("shadow_ready_low", 32'(cfg.CfgReady), 32'd0);
    chk("shadow_upper_old", 32'(TwgUpper), 32'd1000);
    chk("shadow_err",       32'(cfg.CfgErr), 32'd0);
    hold_bad = 1'b0;
    n = 0;
    while (!ValleyTick && n < 200) begin
      tick_clk(); n++;
      if (TwgUpper !== 16'd1000 || TwgLower !== 16'd0 || cfg.CfgReady !== 1'b0) hold_bad = 1'b1;
    end
    chk("valley2_seen", 32'(ValleyTick), 32'd1);
    chk("shadow_held",  32'(hold_bad), 32'd0);
    tick_clk();
    chk("shadow_upper_new", 32'(TwgUpper), 32'd2000);
    chk("shadow_lower_new", 32'(TwgLower), 32'd500);
    chk("shadow_step_new",  32'(TwgStep),  32'd250);
    chk("shadow_ready_back",32'(cfg.CfgReady), 32'd1);
    chk("valley2_cnt",      32'(PeriodCnt), 32'd2);

    // Stop on the rising slope: drain to the next valley
    StopReq = 1'b1;
    tick_clk();
    StopReq = 1'b0;
    chk("drain_running", 32'(Running), 32'd1);
    chk("drain_en",      32'(TwgEn),   32'd1);
    hold_bad = 1'b0;
    n = 0;
    while (!ValleyTick && n < 300) begin
      tick_clk(); n++;
      if (Running !== 1'b1 || TwgEn !== 1'b1) hold_bad = 1'b1;
    end
    chk("drain_valley_seen", 32'(ValleyTick), 32'd1);
    chk("drain_held",        32'(hold_bad), 32'd0);
    tick_clk();
    chk("drain_idle_running", 32'(Running), 32'd0);
    chk("drain_idle_en",      32'(TwgEn),   32'd0);
    chk("drain_cnt",          32'(PeriodCnt), 32'd3);

    // Start and Stop together in IDLE: Stop wins
    StartReq = 1'b1;
    StopReq  = 1'b1;
    tick_clk();
    StartReq = 1'b0;
    StopReq  = 1'b0;
    chk("startstop_running", 32'(Running), 32'd0);
    chk("startstop_en",      32'(TwgEn),   32'd0);

    // Reset in RUN with a pending shadow config
    StartReq = 1'b1;
    tick_clk();
    StartReq = 1'b0;
    chk("rerun_running", 32'(Running), 32'd1);
    tick_clk();
    cfg.CfgValid = 1'b1;
    cfg.CfgUpper = 16'd3000;
    cfg.CfgLower = 16'd0;
    cfg.CfgStep  = 16'd10;
    tick_clk();
    cfg.CfgValid = 1'b0;
    chk("rerun_pending", 32'(cfg.CfgReady), 32'd0);
    RstN = 1'b0;
    tick_clk();
    check_reset_vals("midrst");
    RstN = 1'b1;
    tick_clk();
    chk("midrst_lost_upper", 32'(TwgUpper), 32'hFFFF);
    chk("midrst_lost_step",  32'(TwgStep),  32'h0001);
    chk("midrst_ready",      32'(cfg.CfgReady), 32'd1);
    StartReq = 1'b1;
    tick_clk();
    StartReq = 1'b0;
    chk("midrst_unloaded_start", 32'(Running), 32'd0);

    // Randomized phase against the reference model
    use_gen = 1'b0;
    RstN = 1'b0;
    tick_clk();
    model_reset();
    RstN = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      RstN = ($urandom_range(0, 199) != 0);
      cfg.CfgValid = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rc.u = 16'($urandom); rc.l = 16'($urandom); rc.s = 16'($urandom_range(0, 3));
      end else begin
        rc.l = 16'($urandom_range(0, 1000));
        rc.u = rc.l + 16'($urandom_range(0, 500));
        rc.s = 16'($urandom_range(0, int'(rc.u) - int'(rc.l) + 2));
      end
      cfg.CfgUpper = rc.u;
      cfg.CfgLower = rc.l;
      cfg.CfgStep  = rc.s;
      StartReq = ($urandom_range(0, 9) == 0);
      StopReq  = ($urandom_range(0, 19) == 0);
      TWave    = 16'($urandom_range(0, 7));
      #1;
      chk("rnd_ready",   32'(cfg.CfgReady), 32'(!m_pend));
      chk("rnd_err",     32'(cfg.CfgErr),   32'(m_err));
      chk("rnd_en",      32'(TwgEn),        32'(m_run));
      chk("rnd_running", 32'(Running),      32'(m_run));
      chk("rnd_upper",   32'(TwgUpper),     32'(m_act.u));
      chk("rnd_lower",   32'(TwgLower),     32'(m_act.l));
      chk("rnd_step",    32'(TwgStep),      32'(m_act.s));
      chk("rnd_valley",  32'(ValleyTick),   32'(m_tick(TWave)));
      chk("rnd_cnt",     32'(PeriodCnt),    32'(m_cnt));
      @(posedge MClk);
      model_update(RstN, cfg.CfgValid, rc, StartReq, StopReq, TWave);
      @(negedge MClk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
